// File: rtl/strobe_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to FIR strobe/ack bridge.
package strobe_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_REL,
        RD_REQ,
        RD_REL,
        BRESP,
        RRESP
    } bridge_state_t;

    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_COEFF  = 2'd1;
    localparam logic [1:0] REG_HIST   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ack_sync.sv
// Two-flop level synchronizer for an acknowledge coming from another clock domain.
module ack_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_o <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_o <= meta_q;
        end
    end

endmodule

// File: rtl/axi_strobe_bridge.sv
// AXI4-Lite slave driving the FIR strobe/ack register port with a 4-phase handshake.
// Define STROBE_BRIDGE_ACK_SYNC_EN to pass both acks through 2-flop synchronizers.
module axi_strobe_bridge
    import strobe_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [3:0]        s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              axi_wr_strobe_o,
    input  logic              axi_wr_ack_i,
    output logic              axi_rd_strobe_o,
    input  logic              axi_rd_ack_i,
    output logic [DATA_W-1:0] fir_addr_o,
    output logic [DATA_W-1:0] fir_coeff_o,
    input  logic [DATA_W-1:0] hist_bin_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    bridge_state_t    state, state_nxt;
    logic [CNT_W-1:0] phase_cnt;
    logic             last_was_write;
    logic             timeout_sticky;
    logic             wr_ack, rd_ack;
    logic             acc_wr, acc_rd;
    logic             phase_expired;
    logic             to_evt;
    logic             busy;
    logic [1:0]       aw_idx, ar_idx;
    logic             unused_ok;

`ifdef STROBE_BRIDGE_ACK_SYNC_EN
    ack_sync u_wr_ack_sync (.clk(clk), .rst_n(rst_n), .async_i(axi_wr_ack_i), .sync_o(wr_ack));
    ack_sync u_rd_ack_sync (.clk(clk), .rst_n(rst_n), .async_i(axi_rd_ack_i), .sync_o(rd_ack));
`else
    assign wr_ack = axi_wr_ack_i;
    assign rd_ack = axi_rd_ack_i;
`endif

    assign aw_idx        = s_axi_awaddr[3:2];
    assign ar_idx        = s_axi_araddr[3:2];
    assign phase_expired = (phase_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign busy          = (state != IDLE);
    assign unused_ok     = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wstrb,
                             s_axi_wdata[31:DATA_W]};

    // Handshake outputs decode straight from the state register so that reset drops them at once
    assign s_axi_awready   = acc_wr;
    assign s_axi_wready    = acc_wr;
    assign s_axi_arready   = acc_rd;
    assign s_axi_bvalid    = (state == BRESP);
    assign s_axi_rvalid    = (state == RRESP);
    assign axi_wr_strobe_o = (state == WR_REQ);
    assign axi_rd_strobe_o = (state == RD_REQ);

    always_comb begin
        state_nxt = state;
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        to_evt    = 1'b0;
        case (state)
            IDLE: begin
                // When both are pending, the type not served last time wins
                if (s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !last_was_write)) begin
                    acc_wr    = 1'b1;
                    state_nxt = (aw_idx == REG_COEFF) ? WR_REQ : BRESP;
                end else if (s_axi_arvalid) begin
                    acc_rd    = 1'b1;
                    state_nxt = (ar_idx == REG_HIST) ? RD_REQ : RRESP;
                end
            end
            WR_REQ: begin
                if (wr_ack) begin
                    state_nxt = WR_REL;
                end else if (phase_expired) begin
                    state_nxt = BRESP;
                    to_evt    = 1'b1;
                end
            end
            WR_REL: begin
                if (!wr_ack) begin
                    state_nxt = BRESP;
                end else if (phase_expired) begin
                    state_nxt = BRESP;
                    to_evt    = 1'b1;
                end
            end
            RD_REQ: begin
                if (rd_ack) begin
                    state_nxt = RD_REL;
                end else if (phase_expired) begin
                    state_nxt = RRESP;
                    to_evt    = 1'b1;
                end
            end
            RD_REL: begin
                if (!rd_ack) begin
                    state_nxt = RRESP;
                end else if (phase_expired) begin
                    state_nxt = RRESP;
                    to_evt    = 1'b1;
                end
            end
            BRESP:   if (s_axi_bready) state_nxt = IDLE;
            RRESP:   if (s_axi_rready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            phase_cnt      <= '0;
            last_was_write <= 1'b0;
            timeout_sticky <= 1'b0;
            s_axi_bresp    <= RESP_OKAY;
            s_axi_rresp    <= RESP_OKAY;
            s_axi_rdata    <= '0;
            fir_addr_o     <= '0;
            fir_coeff_o    <= '0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= (state_nxt != state) ? '0 : phase_cnt + 1'b1;

            if (acc_wr) begin
                last_was_write <= 1'b1;
                s_axi_bresp    <= RESP_OKAY;
                case (aw_idx)
                    REG_ADDR:   fir_addr_o  <= s_axi_wdata[DATA_W-1:0];
                    REG_COEFF:  fir_coeff_o <= s_axi_wdata[DATA_W-1:0];
                    REG_STATUS: if (s_axi_wdata[0]) timeout_sticky <= 1'b0;
                    default:    ;
                endcase
            end

            if (acc_rd) begin
                last_was_write <= 1'b0;
                s_axi_rresp    <= RESP_OKAY;
                case (ar_idx)
                    REG_ADDR:   s_axi_rdata <= 32'(fir_addr_o);
                    REG_COEFF:  s_axi_rdata <= 32'(fir_coeff_o);
                    REG_STATUS: s_axi_rdata <= 32'({busy, timeout_sticky});
                    default:    ;
                endcase
            end

            // hist_bin_i is only guaranteed valid while the ack is high
            if (state == RD_REQ && rd_ack) s_axi_rdata <= 32'(hist_bin_i);

            if (to_evt) begin
                timeout_sticky <= 1'b1;
                if (state == WR_REQ || state == WR_REL) begin
                    s_axi_bresp <= RESP_SLVERR;
                end else begin
                    s_axi_rresp <= RESP_SLVERR;
                    s_axi_rdata <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_strobe_bridge.sv
// Scoreboard bench for axi_strobe_bridge with a configurable strobe/ack responder.
module tb_axi_strobe_bridge;

    localparam int TO_CYC = 16;
`ifdef STROBE_BRIDGE_ACK_SYNC_EN
    localparam int EXP_LAT    = 8;
    localparam int EXP_STBLEN = 6;
`else
    localparam int EXP_LAT    = 4;
    localparam int EXP_STBLEN = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b1;
    logic [3:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic        axi_wr_strobe_o, axi_wr_ack_i, axi_rd_strobe_o, axi_rd_ack_i;
    logic [15:0] fir_addr_o, fir_coeff_o;
    logic [15:0] hist_bin_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int   ack_delay = 3;
    bit   ack_never = 1'b0;
    int   wr_cnt, rd_cnt;
    logic wr_ack_d, rd_ack_d;

    int          wr_pulses = 0, rd_pulses = 0, wr_len = 0, rd_len = 0;
    logic [15:0] cap_addr = '0, cap_coeff = '0;
    logic        wr_prev = 1'b0, rd_prev = 1'b0;

    axi_strobe_bridge #(.TIMEOUT_CYC(TO_CYC), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .axi_wr_strobe_o(axi_wr_strobe_o), .axi_wr_ack_i(axi_wr_ack_i),
        .axi_rd_strobe_o(axi_rd_strobe_o), .axi_rd_ack_i(axi_rd_ack_i),
        .fir_addr_o(fir_addr_o), .fir_coeff_o(fir_coeff_o), .hist_bin_i(hist_bin_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Peer model: ack follows the strobe combinationally, after N cycles, or never
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= 0; rd_cnt <= 0; wr_ack_d <= 1'b0; rd_ack_d <= 1'b0;
        end else begin
            if (axi_wr_strobe_o) begin
                wr_cnt <= wr_cnt + 1;
                if (wr_cnt + 1 >= ack_delay) wr_ack_d <= 1'b1;
            end else begin
                wr_cnt <= 0; wr_ack_d <= 1'b0;
            end
            if (axi_rd_strobe_o) begin
                rd_cnt <= rd_cnt + 1;
                if (rd_cnt + 1 >= ack_delay) rd_ack_d <= 1'b1;
            end else begin
                rd_cnt <= 0; rd_ack_d <= 1'b0;
            end
        end
    end
    assign axi_wr_ack_i = ack_never ? 1'b0 : ((ack_delay == 0) ? axi_wr_strobe_o : wr_ack_d);
    assign axi_rd_ack_i = ack_never ? 1'b0 : ((ack_delay == 0) ? axi_rd_strobe_o : rd_ack_d);

    // Strobe monitor: exclusivity, pulse count/length, operand stability
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi_wr_strobe_o || axi_rd_strobe_o)
                chk("strobe_overlap", 32'(axi_wr_strobe_o & axi_rd_strobe_o), 32'd0);
            if (axi_wr_strobe_o) begin
                if (!wr_prev) begin
                    wr_pulses++; wr_len = 1; cap_addr = fir_addr_o; cap_coeff = fir_coeff_o;
                end else begin
                    wr_len++;
                    chk("wr_addr_stable", 32'(fir_addr_o), 32'(cap_addr));
                    chk("wr_coeff_stable", 32'(fir_coeff_o), 32'(cap_coeff));
                end
            end
            if (axi_rd_strobe_o) begin
                if (!rd_prev) begin rd_pulses++; rd_len = 1; end
                else rd_len++;
            end
        end
        wr_prev = axi_wr_strobe_o;
        rd_prev = axi_rd_strobe_o;
    end

    // Response monitor: pops the scoreboard on each completed B/R handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && s_axi_bvalid && s_axi_bready) begin
            if (sb.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk({e.tag, "_kind"}, 32'd0, 32'(e.is_rd));
                chk({e.tag, "_bresp"}, 32'(s_axi_bresp), 32'(e.resp));
            end
        end
        if (rst_n && s_axi_rvalid && s_axi_rready) begin
            if (sb.size() == 0) chk("r_unexpected", 32'd1, 32'd0);
            else begin
                e = sb.pop_front();
                chk({e.tag, "_kind"}, 32'd1, 32'(e.is_rd));
                chk({e.tag, "_rresp"}, 32'(s_axi_rresp), 32'(e.resp));
                chk({e.tag, "_rdata"}, s_axi_rdata, e.data);
            end
        end
    end

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
        bit got = 1'b0;
        @(negedge clk);
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            #1;
            if (s_axi_awready && s_axi_wready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("aw_accept_timeout", 32'd0, 32'd1);
        else begin @(posedge clk); #1; end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a);
        bit got = 1'b0;
        @(negedge clk);
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            #1;
            if (s_axi_arready) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) chk("ar_accept_timeout", 32'd0, 32'd1);
        else begin @(posedge clk); #1; end
        s_axi_arvalid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic push_exp(input bit is_rd, input logic [1:0] resp, input logic [31:0] data,
                            input string tag);
        exp_t e;
        e.is_rd = is_rd; e.resp = resp; e.data = data; e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin
        int p0, lat;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd0);
        chk("rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'd0);
        chk("rst_strobes", 32'({axi_wr_strobe_o, axi_rd_strobe_o}), 32'd0);
        chk("rst_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_fir", 32'({fir_addr_o, fir_coeff_o}), 32'd0);
        rst_n = 1'b1;

        // Register write and strobed coefficient write
        p0 = wr_pulses;
        push_exp(0, 2'b00, 0, "wr_addr");
        axi_write(4'h0, 32'h0000_0012);
        drain("wr_addr");
        chk("addr_no_strobe", 32'(wr_pulses - p0), 32'd0);
        push_exp(0, 2'b00, 0, "wr_coeff");
        axi_write(4'h4, 32'h0000_BEEF);
        drain("wr_coeff");
        chk("coeff_pulses", 32'(wr_pulses - p0), 32'd1);
        chk("coeff_cap_addr", 32'(cap_addr), 32'h12);
        chk("coeff_cap_coeff", 32'(cap_coeff), 32'hBEEF);
        chk("coeff_strobe_len", 32'(wr_len), 32'(EXP_STBLEN));

        // Strobed HIST read and plain register reads
        hist_bin_i = 16'h1234;
        p0 = rd_pulses;
        push_exp(1, 2'b00, 32'h0000_1234, "rd_hist");
        axi_read(4'h8);
        drain("rd_hist");
        chk("hist_pulses", 32'(rd_pulses - p0), 32'd1);
        chk("hist_strobe_len", 32'(rd_len), 32'(EXP_STBLEN));
        push_exp(1, 2'b00, 32'h12, "rd_addr");
        axi_read(4'h0);
        push_exp(1, 2'b00, 32'hBEEF, "rd_coeff");
        axi_read(4'h4);
        push_exp(1, 2'b00, 32'h0, "rd_status0");
        axi_read(4'hC);
        drain("rd_regs");

        // Timeouts and sticky flag
        ack_never = 1'b1;
        push_exp(0, 2'b10, 0, "wr_timeout");
        axi_write(4'h4, 32'h0000_5555);
        drain("wr_timeout");
        chk("timeout_strobe_len", 32'(wr_len), 32'(TO_CYC));
        push_exp(1, 2'b00, 32'h1, "status_sticky");
        axi_read(4'hC);
        push_exp(0, 2'b00, 0, "status_clear");
        axi_write(4'hC, 32'h1);
        push_exp(1, 2'b00, 32'h0, "status_cleared");
        axi_read(4'hC);
        push_exp(1, 2'b10, 32'h0, "rd_timeout");
        axi_read(4'h8);
        drain("timeouts");
        ack_never = 1'b0;

        // Round-robin arbitration under continuous contention
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        hist_bin_i = 16'h0A0B;
        push_exp(0, 2'b00, 0, "rr_w1");
        push_exp(1, 2'b00, 32'h0A0B, "rr_r1");
        push_exp(0, 2'b00, 0, "rr_w2");
        push_exp(1, 2'b00, 32'h0A0B, "rr_r2");
        fork
            begin axi_write(4'h4, 32'h1111); axi_write(4'h4, 32'h2222); end
            begin axi_read(4'h8); axi_read(4'h8); end
        join
        drain("rr");

        // bvalid held while bready low; no AR accepted meanwhile
        @(posedge clk); #1 s_axi_bready = 1'b0;
        push_exp(0, 2'b00, 0, "hold_w");
        push_exp(1, 2'b00, 32'h77, "hold_r");
        axi_write(4'h0, 32'h77);
        s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
            chk("hold_no_ar", 32'(s_axi_arready), 32'd0);
        end
        @(posedge clk); #1 s_axi_bready = 1'b1;
        axi_read(4'h0);
        drain("hold");

        // Asynchronous reset in the middle of WR_REQ
        ack_never = 1'b1;
        axi_write(4'h4, 32'h0099);
        @(negedge clk);
        chk("mid_strobe_high", 32'(axi_wr_strobe_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_strobe", 32'({axi_wr_strobe_o, axi_rd_strobe_o}), 32'd0);
        chk("mid_rst_valids", 32'({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready}), 32'd0);
        chk("mid_rst_fir", 32'({fir_addr_o, fir_coeff_o}), 32'd0);
        chk("mid_rst_rdata", s_axi_rdata, 32'd0);
        ack_never = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Write-handshake-to-bvalid latency with a same-cycle ack
        ack_delay = 0;
        push_exp(0, 2'b00, 0, "lat_wr");
        @(negedge clk);
        s_axi_awaddr = 4'h4; s_axi_wdata = 32'hA5A5;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        #1;
        chk("lat_accept", 32'(s_axi_awready), 32'd1);
        lat = 1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (s_axi_bvalid) break;
        end
        chk("wr_latency", 32'(lat), 32'(EXP_LAT));
        drain("lat");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule
